// File: rtl/avalon_bus.sv
// avalon_bus: word-addressed data-bus slave with RAM, LED register, halt flag and a wait-state FSM.
// Optional AVALON_BUS_STATS_EN adds a completed-transaction counter readable at 0xFFFE.
module avalon_bus #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_WORDS   = 4096,
    parameter int WAIT_STATES = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Read,
    input  logic              Write,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] ReadData,
    output logic              Done,
    output logic [DATA_W-1:0] Led,
    output logic              Halted
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-1:0] LED_A  = ADDR_W'(16'hFFF0);
    localparam logic [ADDR_W-1:0] HALT_A = ADDR_W'(16'hFFFF);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state;
    logic [2:0] cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic lat_wr;
    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic [DATA_W-1:0] rd_val;
    logic is_ram;
    logic [IDX_W-1:0] ram_idx;
    assign is_ram  = 32'(lat_addr) < MEM_WORDS;
    assign ram_idx = lat_addr[IDX_W-1:0];
`ifdef AVALON_BUS_STATS_EN
    localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(16'hFFFE);
    logic [DATA_W-1:0] stat_cnt;
    always_ff @(posedge Clock) begin
        if (Reset) stat_cnt <= '0;
        else if (state == RESP) stat_cnt <= stat_cnt + 1'b1;
    end
`endif
    always_comb begin
        rd_val = is_ram ? mem[ram_idx] : lat_addr == LED_A ? Led : '0;
`ifdef AVALON_BUS_STATS_EN
        if (lat_addr == STAT_A) rd_val = stat_cnt;
`endif
    end
    // RAM is never reset; an aborted write never reaches RESP so it is not committed
    always_ff @(posedge Clock) begin
        if (!Reset && state == RESP && lat_wr && is_ram) mem[ram_idx] <= lat_data;
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            Done     <= 1'b0;
            ReadData <= '0;
            Led      <= '0;
            Halted   <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_wr   <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: if (Read || Write) begin
                    lat_addr <= Addr;
                    lat_data <= WriteData;
                    lat_wr   <= Write;
                    cnt      <= '0;
                    state    <= WAIT_STATES == 0 ? RESP : WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == 3'(WAIT_STATES - 1)) state <= RESP;
                end
                RESP: begin
                    Done  <= 1'b1;
                    state <= IDLE;
                    if (lat_wr) begin
                        if (lat_addr == LED_A) Led <= lat_data;
                        if (lat_addr == HALT_A) Halted <= 1'b1;
                    end else begin
                        ReadData <= rd_val;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_bus.sv
// tb_avalon_bus: directed scoreboard bench for avalon_bus (default parameters, WAIT_STATES=1).
module tb_avalon_bus;
    localparam int WS = 1;
    logic clk = 1'b0;
    logic rst, rd, wr, done, halted;
    logic [15:0] wdata, addr, rdata, led;
    int tests = 0;
    int fails = 0;
    logic [15:0] model_mem [bit [15:0]];
    logic [15:0] m_led, m_last;
    logic m_halt;
    int m_count;
    logic [15:0] sb [$];

    avalon_bus dut (
        .Clock(clk), .Reset(rst), .Read(rd), .Write(wr), .WriteData(wdata), .Addr(addr),
        .ReadData(rdata), .Done(done), .Led(led), .Halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (a < 16'd4096) return model_mem.exists(a) ? model_mem[a] : 16'hxxxx;
        if (a == 16'hFFF0) return m_led;
`ifdef AVALON_BUS_STATS_EN
        if (a == 16'hFFFE) return 16'(m_count);
`endif
        return 16'h0000;
    endfunction

    task automatic model_reset();
        m_led = '0; m_last = '0; m_halt = 1'b0; m_count = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; rd = 1'b0; wr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic txn(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d, input string tag);
        int n;
        logic [15:0] exp_rd;
        rd = r; wr = w; addr = a; wdata = d;
        if (w) begin
            if (a < 16'd4096) model_mem[a] = d;
            if (a == 16'hFFF0) m_led = d;
            if (a == 16'hFFFF) m_halt = 1'b1;
        end else begin
            m_last = model_read(a);
        end
        sb.push_back(m_last);
        m_count++;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        chk({tag, "_latency"}, n, WS + 2);
        exp_rd = sb.pop_front();
        chk({tag, "_rdata"}, rdata, exp_rd);
        chk({tag, "_halted"}, halted, m_halt);
        chk({tag, "_led"}, led, m_led);
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        chk({tag, "_pulse"}, done, 1'b0);
    endtask

    initial begin
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; rst = 1'b0;
        @(negedge clk);
        do_reset();
        @(negedge clk);
        chk("rst_done", done, 1'b0);
        chk("rst_rdata", rdata, 16'h0);
        chk("rst_led", led, 16'h0);
        chk("rst_halted", halted, 1'b0);
        txn(0, 1, 16'h0011, 16'h1111, "wr11");
        txn(0, 1, 16'h0010, 16'hBEEF, "wr10");
        txn(1, 0, 16'h0010, 16'h0000, "rd10");
        txn(1, 0, 16'h0011, 16'h0000, "rd11");
        txn(0, 1, 16'hFFF0, 16'h00A5, "wrled");
        txn(1, 0, 16'hFFF0, 16'h0000, "rdled");
        txn(1, 0, 16'h8000, 16'h0000, "rdunmap");
        txn(0, 1, 16'h8000, 16'hFFFF, "wrunmap");
        txn(1, 0, 16'h0010, 16'h0000, "rd10b");
        txn(0, 1, 16'hFFFF, 16'h0001, "halt");
        txn(1, 0, 16'h0011, 16'h0000, "rdpost");
        txn(1, 0, 16'hFFFF, 16'h0000, "rdhalt");
        do_reset();
        @(negedge clk);
        chk("halt_clr", halted, 1'b0);
        chk("led_clr", led, 16'h0);
        txn(1, 1, 16'h0020, 16'h1234, "both");
        txn(1, 0, 16'h0020, 16'h0000, "rd20");
        txn(0, 1, 16'h0030, 16'h5555, "wr30");
        rd = 1'b0; wr = 1'b1; addr = 16'h0030; wdata = 16'hDEAD;
        @(negedge clk);
        rst = 1'b1; wr = 1'b0;
        @(negedge clk);
        chk("abort_done0", done, 1'b0);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_idle", done, 1'b0);
        end
        txn(1, 0, 16'h0030, 16'h0000, "rd30");
        do_reset();
        txn(0, 1, 16'h0040, 16'h0001, "st1");
        txn(1, 0, 16'h0040, 16'h0000, "st2");
        txn(0, 1, 16'hFFFE, 16'h0007, "st3");
        txn(1, 0, 16'hFFFE, 16'h0000, "stat3");
        txn(1, 0, 16'hFFFE, 16'h0000, "stat4");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
